// File: rtl/seq_mult_signed_param_if.sv
// Handshake and operand bundle for seq_mult_signed_param.
// The master side issues start/operands; the slave side returns busy/done/product.
interface seq_mult_signed_param_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     Q;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, Q
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, Q
    );
endinterface

// File: rtl/seq_mult_signed_param.sv
// Sequential sign-magnitude shift-and-add multiplier, one WIDTH x WIDTH product per WIDTH+2 cycles.
// Optional macro SEQ_MULT_EARLY_TERM_EN skips trailing zero multiplier bits in a single edge.
module seq_mult_signed_param #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_mult_signed_param_if.slave  mul_if
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH:0]       prod_q, prod_d;
    logic [WIDTH-1:0]       mag_a_q, mag_a_d;
    logic                   neg_q, neg_d;
    logic [CNT_W-1:0]       iter_q, iter_d;
    logic [2*WIDTH-1:0]     q_q, q_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic [WIDTH-1:0]       mag_a_s, mag_b_s;
    logic [WIDTH:0]         upper_sum_s;
    logic                   early_term_s;

    // State and datapath registers; rst aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            prod_q  <= '0;
            mag_a_q <= '0;
            neg_q   <= 1'b0;
            iter_q  <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            mag_a_q <= mag_a_d;
            neg_q   <= neg_d;
            iter_q  <= iter_d;
            q_q     <= q_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Operand magnitudes; the most-negative value maps onto itself as an unsigned magnitude.
    always_comb begin
        mag_a_s = mul_if.A;
        mag_b_s = mul_if.B;
        if (mul_if.signed_mode && mul_if.A[WIDTH-1]) begin
            mag_a_s = -mul_if.A;
        end else begin
            mag_a_s = mul_if.A;
        end
        if (mul_if.signed_mode && mul_if.B[WIDTH-1]) begin
            mag_b_s = -mul_if.B;
        end else begin
            mag_b_s = mul_if.B;
        end
    end

    // Conditional add of the multiplicand into the upper half of the product register.
    always_comb begin
        if (prod_q[0]) begin
            upper_sum_s = prod_q[2*WIDTH:WIDTH] + {1'b0, mag_a_q};
        end else begin
            upper_sum_s = prod_q[2*WIDTH:WIDTH];
        end
    end

`ifdef SEQ_MULT_EARLY_TERM_EN
    // Detect that every multiplier bit still waiting to be processed is zero.
    always_comb begin
        early_term_s = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i < int'(iter_q)) && prod_q[i]) begin
                early_term_s = 1'b0;
            end else begin
                early_term_s = early_term_s;
            end
        end
    end
`else
    assign early_term_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mul_if.start) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (early_term_s || (iter_q == CNT_W'(1))) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        prod_d  = prod_q;
        mag_a_d = mag_a_q;
        neg_d   = neg_q;
        iter_d  = iter_q;
        q_d     = q_q;
        done_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (mul_if.start) begin
                    mag_a_d = mag_a_s;
                    neg_d   = mul_if.signed_mode & (mul_if.A[WIDTH-1] ^ mul_if.B[WIDTH-1]);
                    prod_d  = {{(WIDTH+1){1'b0}}, mag_b_s};
                    iter_d  = CNT_W'(WIDTH);
                end else begin
                    prod_d  = prod_q;
                    iter_d  = iter_q;
                end
            end
            S_RUN: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (early_term_s) begin
                    prod_d = prod_q >> iter_q;
                    iter_d = '0;
                end else begin
                    prod_d = {upper_sum_s, prod_q[WIDTH-1:0]} >> 1;
                    iter_d = iter_q - CNT_W'(1);
                end
`else
                prod_d = {upper_sum_s, prod_q[WIDTH-1:0]} >> 1;
                iter_d = iter_q - CNT_W'(1);
`endif
            end
            S_FIX: begin
                if (neg_q) begin
                    q_d = -prod_q[2*WIDTH-1:0];
                end else begin
                    q_d = prod_q[2*WIDTH-1:0];
                end
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign mul_if.busy = busy_q;
    assign mul_if.done = done_q;
    assign mul_if.Q    = q_q;

endmodule
